// File: rtl/crc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_pkg: register map, CTRL bit positions and feeder states shared   |
// | by the CRC block and its stream feeder.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package crc_pkg;

  localparam logic [31:0] CRC_DATA_OFS  = 32'h0000_0000;
  localparam logic [31:0] CRC_GPOLY_OFS = 32'h0000_0004;
  localparam logic [31:0] CRC_CTRL_OFS  = 32'h0000_0008;

  localparam int CTRL_TCRC     = 24;
  localparam int CTRL_WAS      = 25;
  localparam int CTRL_FXOR     = 26;
  localparam int CTRL_TOTR_LSB = 28;
  localparam int CTRL_TOTR_MSB = 29;
  localparam int CTRL_TOT_LSB  = 30;
  localparam int CTRL_TOT_MSB  = 31;

  localparam logic [31:0] CTRL_WAS_MASK = 32'h1 << CTRL_WAS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_CTRL1 = 3'd1,
    ST_W_POLY  = 3'd2,
    ST_W_SEED  = 3'd3,
    ST_W_CTRL2 = 3'd4,
    ST_DATA    = 3'd5,
    ST_READ    = 3'd6,
    ST_DONE    = 3'd7
  } feeder_state_e;

  // Plain-vector encodings of the same states for the legacy FSM register.
  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_W_CTRL1 = 3'd1;
  localparam logic [2:0] c_ST_W_POLY  = 3'd2;
  localparam logic [2:0] c_ST_W_SEED  = 3'd3;
  localparam logic [2:0] c_ST_W_CTRL2 = 3'd4;
  localparam logic [2:0] c_ST_DATA    = 3'd5;
  localparam logic [2:0] c_ST_READ    = 3'd6;
  localparam logic [2:0] c_ST_DONE    = 3'd7;

  function automatic logic [31:0] ctrl_with_was(input logic [31:0] ctrl, input logic was);
    return was ? (ctrl | CTRL_WAS_MASK) : (ctrl & ~CTRL_WAS_MASK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_feed_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_feed_fifo: synchronous DEPTH x 32 FIFO feeding the CRC writer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module crc_feed_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  logic [31:0]   r_mem [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // The extra pointer MSB separates full from empty when the indices meet.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/crc_stream_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_stream_feeder: programs the CRC block, streams a FIFO-buffered   |
// | word sequence into it and reads back the checksum.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module crc_stream_feeder
  import crc_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4003_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [31:0] cfg_ctrl,
  input  logic [31:0] cfg_poly,
  input  logic [31:0] cfg_seed,
  input  logic [15:0] cfg_len,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        busy,
  output logic        crc_sel,
  output logic        crc_rw,
  output logic [31:0] crc_addr,
  output logic [31:0] crc_wdata,
  input  logic [31:0] crc_rdata
);

  logic [2:0]  r_state;
  logic [31:0] r_ctrl;
  logic [31:0] r_poly;
  logic [31:0] r_seed;
  logic [15:0] r_len;
  logic [15:0] r_accepted;
  logic [15:0] r_sent;
  logic [31:0] r_res_data;

  logic        w_push;
  logic        w_pop;
  logic [31:0] w_fifo_dout;
  logic        w_fifo_full;
  logic        w_fifo_empty;

  crc_feed_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_data),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign busy      = (r_state != c_ST_IDLE);
  assign res_valid = (r_state == c_ST_DONE);
  assign res_data  = r_res_data;
  assign in_ready  = busy && !w_fifo_full && (r_accepted < r_len);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = (r_state == c_ST_DATA) && !w_fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_ctrl     <= '0;
      r_poly     <= '0;
      r_seed     <= '0;
      r_len      <= '0;
      r_accepted <= '0;
      r_sent     <= '0;
      r_res_data <= '0;
    end else begin
      if (w_push) r_accepted <= r_accepted + 16'd1;
      case (r_state)
        c_ST_IDLE: begin
          if (cfg_start) begin
            r_ctrl     <= cfg_ctrl;
            r_poly     <= cfg_poly;
            r_seed     <= cfg_seed;
            r_len      <= cfg_len;
            r_accepted <= '0;
            r_sent     <= '0;
            r_state    <= c_ST_W_CTRL1;
          end
        end
        c_ST_W_CTRL1: r_state <= c_ST_W_POLY;
        c_ST_W_POLY:  r_state <= c_ST_W_SEED;
        c_ST_W_SEED:  r_state <= c_ST_W_CTRL2;
        c_ST_W_CTRL2: r_state <= (r_len == 16'd0) ? c_ST_READ : c_ST_DATA;
        c_ST_DATA: begin
          // An empty FIFO simply stalls; only real writes advance the count.
          if (w_pop) begin
            r_sent <= r_sent + 16'd1;
            if (r_sent + 16'd1 == r_len) r_state <= c_ST_READ;
          end
        end
        c_ST_READ: begin
          r_res_data <= crc_rdata;
          r_state    <= c_ST_DONE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Bus is decoded from registered state and FIFO pointers only.
  always_comb begin
    crc_sel   = 1'b0;
    crc_rw    = 1'b0;
    crc_addr  = '0;
    crc_wdata = '0;
    case (r_state)
      c_ST_W_CTRL1: begin
        crc_sel   = 1'b1;
        crc_rw    = 1'b1;
        crc_addr  = BASE_ADDR + CRC_CTRL_OFS;
        crc_wdata = ctrl_with_was(r_ctrl, 1'b1);
      end
      c_ST_W_POLY: begin
        crc_sel   = 1'b1;
        crc_rw    = 1'b1;
        crc_addr  = BASE_ADDR + CRC_GPOLY_OFS;
        crc_wdata = r_poly;
      end
      c_ST_W_SEED: begin
        crc_sel   = 1'b1;
        crc_rw    = 1'b1;
        crc_addr  = BASE_ADDR + CRC_DATA_OFS;
        crc_wdata = r_seed;
      end
      c_ST_W_CTRL2: begin
        crc_sel   = 1'b1;
        crc_rw    = 1'b1;
        crc_addr  = BASE_ADDR + CRC_CTRL_OFS;
        crc_wdata = ctrl_with_was(r_ctrl, 1'b0);
      end
      c_ST_DATA: begin
        if (!w_fifo_empty) begin
          crc_sel   = 1'b1;
          crc_rw    = 1'b1;
          crc_addr  = BASE_ADDR + CRC_DATA_OFS;
          crc_wdata = w_fifo_dout;
        end
      end
      c_ST_READ: begin
        crc_sel  = 1'b1;
        crc_addr = BASE_ADDR + CRC_DATA_OFS;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
